// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and
// counter sizing.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bits needed for a bit index that runs 0..width.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder; the only arithmetic in the serial datapath.
module full_adder_cell (
  output logic sum,
  output logic carry,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_subtractor.sv
// Bit-serial A+B / A-B over WIDTH+1 bits, LSB first, one full-adder cell and
// a carry flop; operands in and result out over valid/ready.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | in_ready high, waiting for operands
//   S_BUSY | one bit per clock; one extra cycle after bit WIDTH to publish
//   S_DONE | out_valid high, y/cout held until out_ready
module serial_adder_subtractor
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   y,
  output logic             cout
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH);
  localparam logic [CW-1:0] BIT_COUT  = CW'(WIDTH - 1);

  state_t          state;
  state_t          state_nxt;
  logic [WIDTH:0]  a_sr;
  logic [WIDTH:0]  b_sr;
  logic [WIDTH:0]  sum_sr;
  logic            carry;
  logic            cout_cap;
  logic            fin;
  logic [CW-1:0]   count;
  logic            fa_sum;
  logic            fa_carry;

  full_adder_cell u_fa (
    .sum   (fa_sum),
    .carry (fa_carry),
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .cin   (carry)
  );

  assign in_ready = (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)  state_nxt = S_BUSY;
      S_BUSY:  if (fin)       state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: B is inverted and extended with ctrl, carry seeded with ctrl.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      carry     <= 1'b0;
      cout_cap  <= 1'b0;
      fin       <= 1'b0;
      count     <= '0;
      y         <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sr  <= {1'b0, a};
            b_sr  <= {ctrl, b ^ {WIDTH{ctrl}}};
            carry <= ctrl;
            count <= '0;
            fin   <= 1'b0;
          end
        end
        S_BUSY: begin
          if (fin) begin
            y         <= sum_sr;
            cout      <= cout_cap;
            out_valid <= 1'b1;
          end else begin
            sum_sr <= {fa_sum, sum_sr[WIDTH:1]};
            a_sr   <= {1'b0, a_sr[WIDTH:1]};
            b_sr   <= {1'b0, b_sr[WIDTH:1]};
            carry  <= fa_carry;
            if (count == BIT_COUT) cout_cap <= fa_carry;
            if (count == BIT_LAST) fin <= 1'b1;
            else                   count <= count + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Bench for serial_adder_subtractor (WIDTH=7): directed table, back-pressure
// and reset-abort sequences, then a random sweep against an arithmetic model.
module tb_serial_adder_subtractor;

  localparam int W = 7;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ctrl;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   y;
  logic         cout;

  int checks = 0;
  int errors = 0;

  serial_adder_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int va;
    int vb;
    bit vc;
    int ey;
    bit ec;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int ref_y(input int ra, input int rb, input bit rc);
    int r;
    r = rc ? (ra - rb) : (ra + rb);
    return r & 255;
  endfunction

  function automatic bit ref_cout(input int ra, input int rb, input bit rc);
    return rc ? (ra >= rb) : ((ra + rb) >= 128);
  endfunction

  // Starts at a negedge with the DUT idle; returns at the negedge where out_valid is first seen.
  task automatic do_op(input int ta, input int tb_v, input bit tc,
                       output int ry, output bit rc, output int lat);
    a        = W'(ta);
    b        = W'(tb_v);
    ctrl     = tc;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk("result_timeout", 0, 1);
    ry = int'(y);
    rc = cout;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t vecs[7];
    int   ry;
    bit   rc;
    int   lat;
    int   y0;
    bit   c0;
    int   ra;
    int   rb;
    bit   rcl;
    int   pick;

    vecs[0] = '{100,  27, 1'b0, 8'h7F, 1'b0};
    vecs[1] = '{127, 127, 1'b0, 8'hFE, 1'b1};
    vecs[2] = '{ 20,  50, 1'b1, 8'hE2, 1'b0};
    vecs[3] = '{ 50,  20, 1'b1, 8'h1E, 1'b1};
    vecs[4] = '{  0,   0, 1'b1, 8'h00, 1'b1};
    vecs[5] = '{  0, 127, 1'b1, 8'h81, 1'b0};
    vecs[6] = '{ 64,  64, 1'b0, 8'h80, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; ctrl = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_cout", int'(cout), 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      chk("vec_in_ready", int'(in_ready), 1);
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vc, ry, rc, lat);
      chk($sformatf("vec%0d_y", i), ry, vecs[i].ey);
      chk($sformatf("vec%0d_cout", i), int'(rc), int'(vecs[i].ec));
      chk($sformatf("vec%0d_latency", i), lat, W + 2);
      finish_op();
    end

    // Back-pressure with stray in_valid pulses during BUSY and DONE.
    a = 7'd100; b = 7'd27; ctrl = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    a = 7'd5; b = 7'd9; ctrl = 1'b1; in_valid = 1'b1;
    chk("bp_busy_in_ready", int'(in_ready), 0);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_out_valid", int'(out_valid), 1);
    y0 = int'(y);
    c0 = cout;
    chk("bp_y", y0, 8'h7F);
    chk("bp_cout", int'(c0), 0);
    for (int k = 0; k < 5; k++) begin
      in_valid = (k == 2);
      @(negedge clk);
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_y", int'(y), 8'h7F);
      chk("bp_hold_cout", int'(cout), 0);
      chk("bp_hold_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    finish_op();
    chk("bp_release_in_ready", int'(in_ready), 1);
    chk("bp_release_out_valid", int'(out_valid), 0);

    // Reset in the middle of BUSY after three bits.
    a = 7'd100; b = 7'd27; ctrl = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_y", int'(y), 0);
    chk("abort_cout", int'(cout), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready_next", int'(in_ready), 1);
    chk("abort_no_stale_valid", int'(out_valid), 0);
    do_op(1, 1, 1'b0, ry, rc, lat);
    chk("abort_then_1p1_y", ry, 8'h02);
    chk("abort_then_1p1_cout", int'(rc), 0);
    finish_op();

    // Random sweep; out_ready held high throughout, including while BUSY.
    out_ready = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      pick = $urandom_range(0, 15);
      ra   = (pick == 0) ? 0 : (pick == 1) ? 127 : $urandom_range(0, 127);
      rb   = (pick == 2) ? 0 : (pick == 3) ? 127 : $urandom_range(0, 127);
      rcl  = $urandom_range(0, 1);
      do_op(ra, rb, rcl, ry, rc, lat);
      checks++;
      if (ry != ref_y(ra, rb, rcl) || rc != ref_cout(ra, rb, rcl) || lat != W + 2) begin
        errors++;
        $display("FAIL rand a=%0d b=%0d sub=%0d actual y=%0d cout=%0d lat=%0d required y=%0d cout=%0d lat=%0d",
                 ra, rb, rcl, ry, rc, lat, ref_y(ra, rb, rcl), ref_cout(ra, rb, rcl), W + 2);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
